// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: instruction memory address/data, redirect, and the
// registered fetch/decode handshake with pre-split instruction fields.
interface instruction_fetch_if;
   logic        start;
   logic [31:0] imem_address;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_ready;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [5:0]  if_opcode;
   logic [4:0]  if_dst;
   logic [4:0]  if_src1;
   logic [4:0]  if_src2;
   logic [15:0] if_imm;
   logic        busy;
   logic        done;
   logic [15:0] fetch_count;

   modport master (
      input  start, imem_data, redirect_valid, redirect_pc, if_ready,
      output imem_address, if_valid, if_instr, if_pc, if_opcode, if_dst,
             if_src1, if_src2, if_imm, busy, done, fetch_count
   );

   modport slave (
      output start, imem_data, redirect_valid, redirect_pc, if_ready,
      input  imem_address, if_valid, if_instr, if_pc, if_opcode, if_dst,
             if_src1, if_src2, if_imm, busy, done, fetch_count
   );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns pc, registers the memory word one cycle after its fire.
// Holds the word while decode is not ready; redirect flushes it unconsumed.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter logic [31:0] LAST_PC  = 32'd356,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input logic                 clk,
   input logic                 reset,
   instruction_fetch_if.master bus
);
   typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } hold_t;

   state_t      state;
   logic [31:0] pc;
   hold_t       hold;
   logic        valid_q;
   logic [15:0] count_q;
   logic        fire;

   // Redirect wins over a fire, so a flushed word is never replaced in the same edge.
   assign fire = (state == FETCH) && !bus.redirect_valid && (!valid_q || bus.if_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         hold    <= '0;
         valid_q <= 1'b0;
         count_q <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.redirect_valid)
                  pc <= bus.redirect_pc & ~32'd3;
               if (bus.start)
                  state <= FETCH;
            end
            FETCH: begin
               if (bus.redirect_valid) begin
                  pc      <= bus.redirect_pc & ~32'd3;
                  valid_q <= 1'b0;
               end else if (fire) begin
                  hold.instr <= bus.imem_data;
                  hold.pc    <= pc;
                  valid_q    <= 1'b1;
                  pc         <= pc + PC_STEP;
                  if (count_q != 16'hFFFF)
                     count_q <= count_q + 16'd1;
                  if (pc >= LAST_PC)
                     state <= HALT;
               end
            end
            HALT: begin
               if (bus.if_ready)
                  valid_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.imem_address = pc;
   assign bus.if_valid     = valid_q;
   assign bus.if_instr     = hold.instr;
   assign bus.if_pc        = hold.pc;
   assign bus.if_opcode    = hold.instr[31:26];
   assign bus.if_dst       = hold.instr[25:21];
   assign bus.if_src1      = hold.instr[20:16];
   assign bus.if_src2      = hold.instr[15:11];
   assign bus.if_imm       = hold.instr[15:0];
   assign bus.busy         = (state == FETCH);
   assign bus.done         = (state == HALT) && !valid_q;
   assign bus.fetch_count  = count_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: basic fetch, stall, redirect,
// mid-run reset, full program run and sticky halt.
module tb_instruction_fetch;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   passed = 0;
   int   n;

   instruction_fetch_if bus();

   instruction_fetch dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input int i);
      logic [7:0] b;
      b = i[7:0];
      if (i == 0) return 32'h8D10_0200;
      if (i == 1) return 32'h01C8_4818;
      return {b ^ 8'h3C, b, 16'hBEEF ^ {8'h00, b}};
   endfunction

   always_comb begin
      bus.imem_data = 32'hDEAD_BEEF;
      if (bus.imem_address < 32'd512)
         bus.imem_data = word(int'(bus.imem_address >> 2));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'd0;
      bus.if_ready = 1'b0;
      step();
      step();
      check("rst_valid", bus.if_valid, 0);
      check("rst_instr", bus.if_instr, 0);
      check("rst_pc", bus.if_pc, 0);
      check("rst_addr", bus.imem_address, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_count", bus.fetch_count, 0);

      // cycle 0: start pulse
      reset = 1'b0;
      bus.start = 1'b1;
      bus.if_ready = 1'b1;
      step();
      bus.start = 1'b0;
      check("c1_busy", bus.busy, 1);
      check("c1_valid", bus.if_valid, 0);
      step();
      check("c2_valid", bus.if_valid, 1);
      check("c2_pc", bus.if_pc, 0);
      check("c2_op", bus.if_opcode, 6'h23);
      check("c2_dst", bus.if_dst, 8);
      check("c2_src1", bus.if_src1, 16);
      check("c2_imm", bus.if_imm, 16'h0200);
      step();
      check("c3_pc", bus.if_pc, 4);
      check("c3_op", bus.if_opcode, 0);
      check("c3_dst", bus.if_dst, 14);
      check("c3_src1", bus.if_src1, 8);
      check("c3_src2", bus.if_src2, 9);
      for (int k = 4; k <= 8; k++) begin
         step();
         check("seq_pc", bus.if_pc, 32'(4 * (k - 2)));
      end

      // stall at if_pc 24
      bus.if_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("stall_pc", bus.if_pc, 24);
         check("stall_instr", bus.if_instr, word(6));
         check("stall_addr", bus.imem_address, 28);
         check("stall_count", bus.fetch_count, 7);
         check("stall_valid", bus.if_valid, 1);
      end
      bus.if_ready = 1'b1;
      step();
      check("release_pc", bus.if_pc, 28);
      check("release_instr", bus.if_instr, word(7));
      check("release_count", bus.fetch_count, 8);

      // redirect with a valid word held and decode ready
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_00F2;
      step();
      bus.redirect_valid = 1'b0;
      check("redir_valid", bus.if_valid, 0);
      check("redir_addr", bus.imem_address, 32'hF0);
      check("redir_count", bus.fetch_count, 8);
      step();
      check("redir_pc", bus.if_pc, 32'hF0);
      check("redir_instr", bus.if_instr, word(60));

      // steer to pc 100, then reset there
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'd100;
      step();
      bus.redirect_valid = 1'b0;
      check("pre_rst_addr", bus.imem_address, 100);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mrst_addr", bus.imem_address, 0);
      check("mrst_valid", bus.if_valid, 0);
      check("mrst_instr", bus.if_instr, 0);
      check("mrst_pc", bus.if_pc, 0);
      check("mrst_count", bus.fetch_count, 0);
      check("mrst_busy", bus.busy, 0);
      check("mrst_done", bus.done, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("idle_valid", bus.if_valid, 0);
         check("idle_addr", bus.imem_address, 0);
      end

      // full program run
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      n = 0;
      for (int k = 0; k < 100; k++) begin
         step();
         if (bus.if_valid) begin
            check("run_pc", bus.if_pc, 32'(n * 4));
            check("run_instr", bus.if_instr, word(n));
            if (n == 89) check("run_busy_fall", bus.busy, 0);
            n = n + 1;
         end
      end
      check("run_words", 32'(n), 90);
      check("run_count", bus.fetch_count, 90);
      check("run_done", bus.done, 1);
      check("run_busy", bus.busy, 0);
      check("run_addr", bus.imem_address, 360);

      // halt ignores start and redirect
      bus.start = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h40;
      step();
      bus.start = 1'b0;
      bus.redirect_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check("halt_addr", bus.imem_address, 360);
         check("halt_done", bus.done, 1);
         check("halt_busy", bus.busy, 0);
         check("halt_valid", bus.if_valid, 0);
         check("halt_count", bus.fetch_count, 90);
         step();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
